// File: rtl/hack_data_memory.sv
// Hack data-memory responder: 16K-word RAM, 8K-word screen shadow with a
// show-ahead write FIFO toward the display controller, and the keyboard
// register. Reads are combinational; all state updates on the rising edge.
module hack_data_memory #(
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [15:0]        addressM,
   input  logic               writeM,
   input  logic [15:0]        outM,
   output logic [15:0]        inM,
   input  logic               key_valid,
   input  logic [15:0]        key_code,
   output logic               key_ready,
   output logic               scr_wr_valid,
   output logic [12:0]        scr_wr_addr,
   output logic [15:0]        scr_wr_data,
   input  logic               scr_wr_ready,
   output logic               scr_overflow,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_SCR  = 2'd1,
      REG_KBD  = 2'd2,
      REG_NONE = 2'd3
   } region_e;

   // Address bit 15 has no meaning in the Hack map.
   logic        unused_addr_msb_s;
   logic [14:0] addr_s;
   assign unused_addr_msb_s = addressM[15];
   assign addr_s            = addressM[14:0];

   // Storage arrays: deliberately never reset so contents survive reset.
   logic [15:0] ram_q       [0:16383];
   logic [15:0] shadow_q    [0:8191];
   logic [12:0] fifo_addr_q [0:FIFO_DEPTH-1];
   logic [15:0] fifo_data_q [0:FIFO_DEPTH-1];

   // Control state.
   logic [15:0]        kbd_q,       kbd_d;
   logic [FIFO_AW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [FIFO_AW:0]   level_q,     level_d;
   logic               overflow_q,  overflow_d;
   logic               key_ready_q;

   region_e region_s;
   logic    ram_we_s;
   logic    push_req_s;
   logic    push_ok_s;
   logic    drop_s;
   logic    pop_s;
   logic    full_s;
   logic    fifo_valid_s;
   logic    key_take_s;

   // Decode the 15-bit address into one of the four memory-map regions.
   always_comb begin
      region_s = REG_NONE;
      if (addr_s[14] == 1'b0) begin
         region_s = REG_RAM;
      end else if (addr_s[13] == 1'b0) begin
         region_s = REG_SCR;
      end else if (addr_s[12:0] == 13'h0000) begin
         region_s = REG_KBD;
      end else begin
         region_s = REG_NONE;
      end
   end

   // Zero-latency read mux; arrays are read before this edge's write lands,
   // so a read-during-write shows the old word.
   always_comb begin
      inM = 16'h0000;
      case (region_s)
         REG_RAM:  inM = ram_q[addr_s[13:0]];
         REG_SCR:  inM = shadow_q[addr_s[12:0]];
         REG_KBD:  inM = kbd_q;
         REG_NONE: inM = 16'h0000;
         default:  inM = 16'h0000;
      endcase
   end

   // FIFO push/pop arbitration, level and pointer next state, keyboard capture.
   always_comb begin
      fifo_valid_s = (level_q != {(FIFO_AW + 1){1'b0}});
      full_s       = (level_q == DEPTH_C);
      pop_s        = fifo_valid_s && scr_wr_ready;
      ram_we_s     = writeM && (region_s == REG_RAM);
      push_req_s   = writeM && (region_s == REG_SCR);
      push_ok_s    = 1'b0;
      drop_s       = 1'b0;
      key_take_s   = key_valid && key_ready_q;

      // A full FIFO still accepts a push when the head leaves in the same cycle.
      if (push_req_s) begin
         if (!full_s || pop_s) begin
            push_ok_s = 1'b1;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         push_ok_s = 1'b0;
         drop_s    = 1'b0;
      end

      case ({push_ok_s, pop_s})
         2'b10:   level_d = level_q + {{FIFO_AW{1'b0}}, 1'b1};
         2'b01:   level_d = level_q - {{FIFO_AW{1'b0}}, 1'b1};
         default: level_d = level_q;
      endcase

      // Pointers are FIFO_AW bits wide, so wrap modulo the power-of-two depth.
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + {{(FIFO_AW - 1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(FIFO_AW - 1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      overflow_d = overflow_q | drop_s;

      if (key_take_s) begin
         kbd_d = key_code;
      end else begin
         kbd_d = kbd_q;
      end
   end

   // Control registers with asynchronous clear; pending FIFO entries vanish at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         kbd_q       <= 16'h0000;
         wr_ptr_q    <= {FIFO_AW{1'b0}};
         rd_ptr_q    <= {FIFO_AW{1'b0}};
         level_q     <= {(FIFO_AW + 1){1'b0}};
         overflow_q  <= 1'b0;
         key_ready_q <= 1'b0;
      end else begin
         kbd_q       <= kbd_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         key_ready_q <= 1'b1;
      end
   end

   // RAM and screen-shadow writes; the shadow updates even when the FIFO drops.
   always_ff @(posedge clock) begin
      if (reset && ram_we_s) begin
         ram_q[addr_s[13:0]] <= outM;
      end
      if (reset && push_req_s) begin
         shadow_q[addr_s[12:0]] <= outM;
      end
   end

   // FIFO entry storage; only accepted pushes occupy a slot.
   always_ff @(posedge clock) begin
      if (reset && push_ok_s) begin
         fifo_addr_q[wr_ptr_q] <= addr_s[12:0];
         fifo_data_q[wr_ptr_q] <= outM;
      end
   end

   assign key_ready    = key_ready_q;
   assign scr_wr_valid = (level_q != {(FIFO_AW + 1){1'b0}});
   assign scr_wr_addr  = fifo_addr_q[rd_ptr_q];
   assign scr_wr_data  = fifo_data_q[rd_ptr_q];
   assign scr_overflow = overflow_q;
   assign fifo_level   = level_q;

endmodule

// File: tb/tb_hack_data_memory.sv
// Testbench for hack_data_memory: behavioural memory-map model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_hack_data_memory;

   localparam int DEPTH = 8;

   logic        clock        = 1'b0;
   logic        reset        = 1'b1;
   logic [15:0] addressM     = 16'h6001;
   logic        writeM       = 1'b0;
   logic [15:0] outM         = 16'h0000;
   logic [15:0] inM;
   logic        key_valid    = 1'b0;
   logic [15:0] key_code     = 16'h0000;
   logic        key_ready;
   logic        scr_wr_valid;
   logic [12:0] scr_wr_addr;
   logic [15:0] scr_wr_data;
   logic        scr_wr_ready = 1'b0;
   logic        scr_overflow;
   logic [3:0]  fifo_level;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   hack_data_memory #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .addressM     (addressM),
      .writeM       (writeM),
      .outM         (outM),
      .inM          (inM),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ready    (key_ready),
      .scr_wr_valid (scr_wr_valid),
      .scr_wr_addr  (scr_wr_addr),
      .scr_wr_data  (scr_wr_data),
      .scr_wr_ready (scr_wr_ready),
      .scr_overflow (scr_overflow),
      .fifo_level   (fifo_level)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] ram_m [16384];
   bit          ram_w [16384];
   logic [15:0] scr_m [8192];
   bit          scr_w [8192];
   logic [15:0] kbd_m = 16'h0000;
   logic [28:0] q_m [$];
   bit          ovf_m = 1'b0;
   bit          kr_m  = 1'b0;
   int          ma;
   int          ca;

   // Reset clears everything except the memory contents, immediately.
   always @(negedge reset) begin
      q_m.delete();
      ovf_m = 1'b0;
      kbd_m = 16'h0000;
      kr_m  = 1'b0;
   end

   // Model update on each rising edge outside reset.
   always @(posedge clock) begin
      if (reset) begin
         ma = int'(addressM[14:0]);
         if (key_valid && kr_m) kbd_m = key_code;
         if (q_m.size() != 0 && scr_wr_ready) void'(q_m.pop_front());
         if (writeM) begin
            if (ma < 16'h4000) begin
               ram_m[ma] = outM;
               ram_w[ma] = 1'b1;
            end else if (ma < 16'h6000) begin
               scr_m[ma - 16'h4000] = outM;
               scr_w[ma - 16'h4000] = 1'b1;
               if (q_m.size() < DEPTH) q_m.push_back({13'(ma - 16'h4000), outM});
               else ovf_m = 1'b1;
            end
         end
         kr_m = 1'b1;
      end
   end

   // Compare DUT outputs with the model on every falling edge.
   always @(negedge clock) begin
      if (check_en) begin
         chk("key_ready", {31'd0, key_ready}, {31'd0, kr_m});
         chk("fifo_level", {28'd0, fifo_level}, q_m.size());
         chk("scr_wr_valid", {31'd0, scr_wr_valid}, {31'd0, q_m.size() != 0});
         chk("scr_overflow", {31'd0, scr_overflow}, {31'd0, ovf_m});
         if (q_m.size() != 0) begin
            chk("head_addr", {19'd0, scr_wr_addr}, {19'd0, q_m[0][28:16]});
            chk("head_data", {16'd0, scr_wr_data}, {16'd0, q_m[0][15:0]});
         end
         ca = int'(addressM[14:0]);
         if (ca < 16'h4000) begin
            if (ram_w[ca]) chk("inM_ram", {16'd0, inM}, {16'd0, ram_m[ca]});
         end else if (ca < 16'h6000) begin
            if (scr_w[ca - 16'h4000]) chk("inM_scr", {16'd0, inM}, {16'd0, scr_m[ca - 16'h4000]});
         end else if (ca == 16'h6000) begin
            chk("inM_kbd", {16'd0, inM}, {16'd0, kbd_m});
         end else begin
            chk("inM_unmapped", {16'd0, inM}, 32'd0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic [15:0] a, input logic we, input logic [15:0] d);
      addressM = a;
      writeM   = we;
      outM     = d;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b0;
      #1 check_en = 1'b1;
      #1;
      chk("rst_level", {28'd0, fifo_level}, 32'd0);
      chk("rst_valid", {31'd0, scr_wr_valid}, 32'd0);
      chk("rst_ovf", {31'd0, scr_overflow}, 32'd0);
      chk("rst_key_ready", {31'd0, key_ready}, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      step();
      chk("key_ready_up", {31'd0, key_ready}, 32'd1);

      // RAM write, read-during-write, readback, unmapped, bit 15 ignored.
      drive(16'h0005, 1'b1, 16'h0BAD); step();
      drive(16'h0005, 1'b1, 16'h1234); #1;
      chk("ram_rdw_old", {16'd0, inM}, 32'h0BAD);
      step();
      drive(16'h0005, 1'b0, 16'h0000); #1;
      chk("ram_read", {16'd0, inM}, 32'h1234);
      drive(16'h8005, 1'b0, 16'h0000); #1;
      chk("ram_bit15", {16'd0, inM}, 32'h1234);
      drive(16'h6001, 1'b0, 16'h0000); #1;
      chk("unmapped", {16'd0, inM}, 32'h0000);
      step();

      // Keyboard capture, hold, release, and CPU write ignored.
      drive(16'h6000, 1'b0, 16'h0000);
      key_valid = 1'b1; key_code = 16'h0041; #1;
      chk("kbd_before", {16'd0, inM}, 32'h0000);
      step();
      key_valid = 1'b0; key_code = 16'h0077; #1;
      chk("kbd_accept", {16'd0, inM}, 32'h0041);
      step(); #1;
      chk("kbd_hold", {16'd0, inM}, 32'h0041);
      key_valid = 1'b1; key_code = 16'h0000; step();
      key_valid = 1'b0; #1;
      chk("kbd_release", {16'd0, inM}, 32'h0000);
      key_valid = 1'b1; key_code = 16'h0041; step();
      key_valid = 1'b0;
      drive(16'h6000, 1'b1, 16'hFFFF); step();
      drive(16'h6000, 1'b0, 16'h0000); #1;
      chk("kbd_cpu_write", {16'd0, inM}, 32'h0041);
      step();

      // Single screen write.
      scr_wr_ready = 1'b0;
      drive(16'h4010, 1'b1, 16'hAAAA); step();
      drive(16'h4010, 1'b0, 16'h0000); #1;
      chk("scr_valid", {31'd0, scr_wr_valid}, 32'd1);
      chk("scr_addr", {19'd0, scr_wr_addr}, 32'h010);
      chk("scr_data", {16'd0, scr_wr_data}, 32'hAAAA);
      chk("scr_level", {28'd0, fifo_level}, 32'd1);
      chk("scr_shadow", {16'd0, inM}, 32'hAAAA);
      scr_wr_ready = 1'b1;
      drive(16'h6001, 1'b0, 16'h0000); step();
      scr_wr_ready = 1'b0; #1;
      chk("scr_drained", {28'd0, fifo_level}, 32'd0);

      // Overflow: nine writes into an eight-deep FIFO.
      for (int i = 0; i < 9; i++) begin
         drive(16'h4000 + 16'(i), 1'b1, 16'h1000 + 16'(i)); step();
      end
      drive(16'h4008, 1'b0, 16'h0000); #1;
      chk("ovf_level", {28'd0, fifo_level}, 32'd8);
      chk("ovf_flag", {31'd0, scr_overflow}, 32'd1);
      chk("ovf_shadow", {16'd0, inM}, 32'h1008);
      scr_wr_ready = 1'b1;
      drive(16'h6001, 1'b0, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("ovf_drain_addr", {19'd0, scr_wr_addr}, i);
         chk("ovf_drain_data", {16'd0, scr_wr_data}, 32'h1000 + i);
         step();
      end
      #1;
      chk("ovf_empty", {28'd0, fifo_level}, 32'd0);
      chk("ovf_sticky", {31'd0, scr_overflow}, 32'd1);
      scr_wr_ready = 1'b0;

      // Asynchronous reset with three entries pending.
      for (int i = 0; i < 3; i++) begin
         drive(16'h4100 + 16'(i), 1'b1, 16'h3000 + 16'(i)); step();
      end
      drive(16'h6001, 1'b0, 16'h0000); #1;
      chk("arst_pre_level", {28'd0, fifo_level}, 32'd3);
      reset = 1'b0; #1;
      chk("arst_level", {28'd0, fifo_level}, 32'd0);
      chk("arst_valid", {31'd0, scr_wr_valid}, 32'd0);
      chk("arst_ovf", {31'd0, scr_overflow}, 32'd0);
      chk("arst_key_ready", {31'd0, key_ready}, 32'd0);
      step();
      reset = 1'b1;
      step();
      drive(16'h0005, 1'b0, 16'h0000); #1;
      chk("arst_ram_kept", {16'd0, inM}, 32'h1234);
      drive(16'h6000, 1'b0, 16'h0000); #1;
      chk("arst_kbd", {16'd0, inM}, 32'h0000);
      step();

      // Push while full with a simultaneous pop.
      scr_wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(16'h5FF0 + 16'(i), 1'b1, 16'h2000 + 16'(i)); step();
      end
      drive(16'h6001, 1'b0, 16'h0000); #1;
      chk("sim_full", {28'd0, fifo_level}, 32'd8);
      scr_wr_ready = 1'b1;
      drive(16'h5FFF, 1'b1, 16'h5555); #1;
      chk("sim_head", {19'd0, scr_wr_addr}, 32'h1FF0);
      step();
      drive(16'h6001, 1'b0, 16'h0000); #1;
      chk("sim_level", {28'd0, fifo_level}, 32'd8);
      chk("sim_no_ovf", {31'd0, scr_overflow}, 32'd0);
      for (int i = 1; i < 8; i++) begin
         #1;
         chk("sim_drain_addr", {19'd0, scr_wr_addr}, 32'h1FF0 + i);
         step();
      end
      #1;
      chk("sim_last_addr", {19'd0, scr_wr_addr}, 32'h1FFF);
      chk("sim_last_data", {16'd0, scr_wr_data}, 32'h5555);
      step(); #1;
      chk("sim_empty", {28'd0, fifo_level}, 32'd0);
      scr_wr_ready = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
